mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
// Initiator side of the 8-bit data-memory port. It takes load/store requests from the CPU
// datapath over a valid/ready handshake and drives memRead/memWrite/input_addr/dataMemWrite
// into the unified memory, then samples readData. Strobes are held for a fixed number of
// wait cycles, and the result comes back as a one-cycle response. Sits between the
// execute/mem stage and the memory block.
// PARAMETERS
// AW           8   address width (256-entry memory)
// DW           8   data width
// WAIT_CYCLES  1   cycles each strobe is held before readData is sampled; legal range
//                  1..15; a value of 0 is an elaboration error ($error)
// PORTS
// clk           in   1   rising-edge clock
// reset         in   1   asynchronous, active-high reset
// req_valid     in   1   request present
// req_ready     out  1   controller can accept a request (IDLE only)
// req_write     in   1   1=store, 0=load
// req_addr      in   AW  target address
// req_wdata     in   DW  store data
// resp_valid    out  1   one-cycle pulse: access complete
// resp_rdata    out  DW  load result; valid with resp_valid
// busy          out  1   high in any non-IDLE state
// memRead       out  1   read strobe to memory
// memWrite      out  1   write strobe to memory
// input_addr    out  AW  memory address
// dataMemWrite  out  DW  memory write data
// readData      in   DW  memory read data (combinational in the memory)
// verify_err    out  1   only with STORE_VERIFY_EN: store read-back mismatch, valid with resp_valid
// BEHAVIOUR
// - Reset (async): state=IDLE, req_ready=1, all other outputs 0, wait counter 0. Any
//   in-flight access is dropped with no response; strobes fall immediately.
// - States: IDLE -> ACCESS -> RESP -> IDLE; with the macro, stores go ACCESS -> VERIFY -> RESP.
// - IDLE: req_ready=1. If req_valid=1 at a clock edge, latch write/addr/wdata and move to
//   ACCESS. Input changes after acceptance have no effect.
// - ACCESS: input_addr and dataMemWrite are driven from the latched values. memRead=~write
//   and memWrite=write are held for exactly WAIT_CYCLES cycles, counted by a 4-bit counter.
//   On the last cycle, a load captures readData into resp_rdata.
// - RESP: both strobes are 0; resp_valid=1 for one cycle. There is no backpressure. After
//   RESP the state returns to IDLE.
// - resp_rdata holds its last load value until the next load. Stores do not alter it.
// - Latency: request accepted at edge N; strobes are high in cycles N+1..N+WAIT_CYCLES;
//   resp_valid is high in cycle N+WAIT_CYCLES+1; req_ready is high again in the next cycle.
//   Maximum throughput is one access per WAIT_CYCLES+2 cycles.
// - Invariants: memRead and memWrite are never high together. Both strobes are low for at
//   least one cycle between accesses. input_addr and dataMemWrite are stable whenever
//   either strobe is high.
// - In IDLE, input_addr and dataMemWrite keep their last values; the strobes are 0.
// - No address arithmetic is performed. The address is passed through unchanged.
// CONFIGURATION
// - STORE_VERIFY_EN defined: after a store's ACCESS phase, the block enters VERIFY.
//   VERIFY asserts memRead at the same address for WAIT_CYCLES cycles, with memWrite=0.
//   On the last VERIFY cycle, readData is compared with the latched wdata, and
//   verify_err = (readData != wdata) is registered. verify_err is shown with resp_valid
//   and is 0 at all other times. Store latency becomes 2*WAIT_CYCLES+1 cycles.
//   Load latency is unchanged.
// - STORE_VERIFY_EN undefined: the VERIFY state and the verify_err port do not exist.
// TESTING
// 1 Assert reset mid-cycle with req_valid=1 -> all outputs 0 and req_ready=1 immediately,
//   with no dependence on clk.
// 2 WAIT_CYCLES=2, memory[0x10]=0x5A, load 0x10 -> memRead high for 2 cycles with
//   input_addr=0x10; resp_valid in the 3rd cycle; resp_rdata=0x5A.
// 3 Store 0x3C to 0x20 -> memWrite high for WAIT_CYCLES cycles with input_addr=0x20 and
//   dataMemWrite=0x3C; a subsequent load of 0x20 returns 0x3C; resp_rdata is unchanged
//   by the store.
// 4 Hold req_valid high with two back-to-back requests -> req_ready=0 from acceptance
//   through RESP; the second request is accepted the cycle after resp_valid; a strobe
//   gap of at least 1 cycle is checked.
// 5 Assert reset during ACCESS of a load from 0x33 -> no resp_valid, strobes drop
//   asynchronously, and the next request completes normally.
// 6 (STORE_VERIFY_EN) Memory model forces bit0 to 0; store 0x01 -> verify_err=1 with
//   resp_valid. Store 0x02 -> verify_err=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the 8-bit data memory: valid/ready request in, timed strobes out, one-cycle response.
// Optional feature: define STORE_VERIFY_EN to read back every store and report a mismatch on verify_err.
module mem_access_ctrl #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          busy,
  output logic          memRead,
  output logic          memWrite,
  output logic [AW-1:0] input_addr,
  output logic [DW-1:0] dataMemWrite,
`ifdef STORE_VERIFY_EN
  output logic          verify_err,
`endif
  input  logic [DW-1:0] readData
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_VERIFY = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wr_q;
  logic          ready_q;
  logic          busy_q;
  logic          resp_q;
  logic          rd_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
`ifdef STORE_VERIFY_EN
  logic          err_q;
`endif

  assign cnt_d = cnt_q - CW'(1);

  // Whole access sequence; every output comes straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef STORE_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q <= S_ACCESS;
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= ~req_write;
            we_q    <= req_write;
            cnt_q   <= CNT_LAST;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            rd_q <= 1'b0;
            we_q <= 1'b0;
            if (!wr_q) begin
              rdata_q <= readData;
            end
`ifdef STORE_VERIFY_EN
            // Stores turn straight into a read of the same address.
            if (wr_q) begin
              state_q <= S_VERIFY;
              rd_q    <= 1'b1;
              cnt_q   <= CNT_LAST;
            end else begin
              state_q <= S_RESP;
              resp_q  <= 1'b1;
            end
`else
            state_q <= S_RESP;
            resp_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef STORE_VERIFY_EN
        S_VERIFY: begin
          if (cnt_q == '0) begin
            rd_q    <= 1'b0;
            err_q   <= (readData != wdata_q);
            state_q <= S_RESP;
            resp_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        S_RESP: begin
          resp_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef STORE_VERIFY_EN
          err_q   <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          resp_q  <= 1'b0;
          rd_q    <= 1'b0;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_q;
  assign resp_rdata   = rdata_q;
  assign memRead      = rd_q;
  assign memWrite     = we_q;
  assign input_addr   = addr_q;
  assign dataMemWrite = wdata_q;
`ifdef STORE_VERIFY_EN
  assign verify_err   = err_q;
`endif

endmodule
